// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : shared types and constants for the fetch-to-decode queue
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  // One fetched instruction with the PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  localparam int unsigned FQ_MAX_DEPTH = 16;

  function automatic bit fq_depth_ok(input int unsigned depth);
    return (depth >= 2) && (depth <= FQ_MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// fetch_queue_if : push/pop handshake, flush controls and status of the queue
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(fetch_data_t),
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ready;
  logic              flush;
  logic              flush_keep;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  // Fetch/decode side that drives the queue.
  modport master (
    output push_valid, push_data, pop_ready, flush, flush_keep,
    input  push_ready, pop_valid, pop_data, count, almost_full
  );

  // The queue itself.
  modport slave (
    input  push_valid, push_data, pop_ready, flush, flush_keep,
    output push_ready, pop_valid, pop_data, count, almost_full
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : circular buffer between fetch and decode with flush and
//               delay-slot-preserving flush_keep
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(fetch_data_t),
  parameter int unsigned DEPTH  = 4
) (
  input  wire         clk,
  input  wire         reset,
  fetch_queue_if.slave fq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (!fq_depth_ok(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two between 2 and %0d", FQ_MAX_DEPTH);
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push_ready;
  logic              pop_valid;
  logic              push_fire;
  logic              pop_fire;
  logic [PTR_W-1:0]  head_inc;
  logic [PTR_W-1:0]  head_inc2;
  logic [PTR_W-1:0]  tail_inc;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push_fire  = fq.push_valid && push_ready;
  assign pop_fire   = pop_valid && fq.pop_ready;
  assign head_inc   = head_q + PTR_W'(1);
  assign head_inc2  = head_q + PTR_W'(2);
  assign tail_inc   = tail_q + PTR_W'(1);

  assign fq.push_ready  = push_ready;
  assign fq.pop_valid   = pop_valid;
  assign fq.pop_data    = mem_q[head_q];
  assign fq.count       = count_q;
  assign fq.almost_full = (count_q >= CNT_W'(DEPTH - 1));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;

    if (fq.flush) begin
      tail_d  = head_q;
      count_d = '0;
    end else if (fq.flush_keep) begin
      // Keep only the oldest entry that survives this cycle's pop.
      if (!pop_fire && pop_valid) begin
        tail_d  = head_inc;
        count_d = CNT_W'(1);
      end else if (pop_fire && (count_q >= CNT_W'(2))) begin
        head_d  = head_inc;
        tail_d  = head_inc2;
        count_d = CNT_W'(1);
      end else begin
        // Nothing survives: an incoming push becomes the delay-slot entry.
        head_d  = tail_q;
        tail_d  = tail_q;
        count_d = '0;
        if (push_fire) begin
          mem_d[tail_q] = fq.push_data;
          tail_d        = tail_inc;
          count_d       = CNT_W'(1);
        end
      end
    end else begin
      if (push_fire) begin
        mem_d[tail_q] = fq.push_data;
        tail_d        = tail_inc;
      end
      if (pop_fire) begin
        head_d = head_inc;
      end
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue (DEPTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;

  logic clk;
  logic reset;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  fetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fq_if ();

  fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pv, input logic [63:0] pd, input bit pr,
                       input bit fl, input bit fk);
    fq_if.push_valid = pv;
    fq_if.push_data  = pd;
    fq_if.pop_ready  = pr;
    fq_if.flush      = fl;
    fq_if.flush_keep = fk;
  endtask

  // One clock of stimulus: check status against the scoreboard, then advance it.
  task automatic step(input bit pv, input logic [63:0] pd, input bit pr,
                      input bit fl, input bit fk);
    int  n;
    bit  push_f, pop_f;
    logic [63:0] keep;
    @(negedge clk);
    drive(pv, pd, pr, fl, fk);
    #1;
    n = sb.size();
    chk("count", 64'(fq_if.count), 64'(n));
    chk("pop_valid", 64'(fq_if.pop_valid), 64'(n != 0));
    chk("push_ready", 64'(fq_if.push_ready), 64'(n != DEPTH));
    chk("almost_full", 64'(fq_if.almost_full), 64'(n >= DEPTH - 1));
    if (n != 0) chk("pop_data", fq_if.pop_data, sb[0]);
    push_f = pv && (n != DEPTH);
    pop_f  = pr && (n != 0);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else if (fk) begin
      if (pop_f) void'(sb.pop_front());
      if (sb.size() >= 1) begin
        keep = sb[0];
        sb.delete();
        sb.push_back(keep);
      end else if (push_f) begin
        sb.push_back(pd);
      end
    end else begin
      if (pop_f) void'(sb.pop_front());
      if (push_f) sb.push_back(pd);
    end
  endtask

  // Idle cycle with literal expectations on count and head data.
  task automatic expect_state(input string tag, input int cnt, input logic [63:0] head);
    @(negedge clk);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk({tag, "_count"}, 64'(fq_if.count), 64'(cnt));
    if (cnt != 0) chk({tag, "_data"}, fq_if.pop_data, head);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(fq_if.count), 64'd0);
    chk("rst_pop_valid", 64'(fq_if.pop_valid), 64'd0);
    chk("rst_push_ready", 64'(fq_if.push_ready), 64'd1);
    chk("rst_almost_full", 64'(fq_if.almost_full), 64'd0);
    chk("rst_pop_data", fq_if.pop_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("full_count", 64'(fq_if.count), 64'd4);
    chk("full_push_ready", 64'(fq_if.push_ready), 64'd0);
    chk("full_almost_full", 64'(fq_if.almost_full), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    expect_state("drained", 0, 64'h0);

    // Full with simultaneous push and pop: pop wins, push rejected.
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h5, 1'b1, 1'b0, 1'b0);
    expect_state("full_pushpop", 3, 64'h2);
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Continuous push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 64'h10 + 64'(i), 1'b1, 1'b0, 1'b0);
    expect_state("wrap", 1, 64'h19);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // flush_keep with a pop firing keeps the second entry.
    step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hF, 1'b1, 1'b0, 1'b1);
    expect_state("fk_pop", 1, 64'hB);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // flush_keep without pop keeps the head.
    step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    expect_state("fk_nopop", 1, 64'hA);
    step(1'b1, 64'h77, 1'b1, 1'b1, 1'b0);
    expect_state("flush", 0, 64'h0);

    // flush_keep on an empty queue accepts the push as the kept entry.
    step(1'b1, 64'hD, 1'b0, 1'b0, 1'b1);
    expect_state("fk_empty_push", 1, 64'hD);
    step(1'b1, 64'hE, 1'b0, 1'b1, 1'b1);
    expect_state("flush_prio", 0, 64'h0);

    // Last entry popped under flush_keep: same-cycle push is kept.
    step(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h21, 1'b1, 1'b0, 1'b1);
    expect_state("fk_pop_last", 1, 64'h21);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation with a push pending.
    step(1'b1, 64'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h32, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 64'h33, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst_count", 64'(fq_if.count), 64'd0);
    chk("midrst_pop_valid", 64'(fq_if.pop_valid), 64'd0);
    chk("midrst_push_ready", 64'(fq_if.push_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    expect_state("post_rst", 0, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
